// File: rtl/relu_pool_gen.sv
// relu_pool_gen: streaming POOLxPOOL max-pool (stride POOL) over a feature map
// held in a producer RAM. Addresses are issued window by window in raster
// order; each returned sample is folded into a running maximum, and one
// result is emitted per window.
// Optional feature macro: RELU_POOL_RELU_EN -- samples are signed and a
// negative window maximum is output as 0 (ReLU). Undefined: unsigned max.

module relu_pool_gen #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 24,
    parameter int IMG_H  = 24,
    parameter int POOL   = 2,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              src_ready,
    input  logic              src_complete,
    input  logic [DATA_W-1:0] d_in,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] d_out,
    output logic              out_valid,
    output logic              done
);

    localparam int WIN_X = IMG_W / POOL;
    localparam int WIN_Y = IMG_H / POOL;
    localparam int OW    = (POOL  > 1) ? $clog2(POOL)  : 1;
    localparam int XW    = (WIN_X > 1) ? $clog2(WIN_X) : 1;
    localparam int YW    = (WIN_Y > 1) ? $clog2(WIN_Y) : 1;

    localparam logic [OW-1:0]     OFF_MAX = OW'(POOL - 1);
    localparam logic [XW-1:0]     WX_MAX  = XW'(WIN_X - 1);
    localparam logic [YW-1:0]     WY_MAX  = YW'(WIN_Y - 1);
    localparam logic [ADDR_W-1:0] POOL_A  = ADDR_W'(POOL);
    localparam logic [ADDR_W-1:0] IMGW_A  = ADDR_W'(IMG_W);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SRC = 2'd1,
        RUN      = 2'd2,
        FLUSH    = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Window position and offset inside the window
    logic [OW-1:0] off_r_q, off_r_d, off_c_q, off_c_d;
    logic [XW-1:0] win_x_q, win_x_d;
    logic [YW-1:0] win_y_q, win_y_d;

    // Capture pipeline: tags travelling one cycle behind the issued address
    logic vld_q, first_q, last_q;

    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] d_out_q;
    logic              out_valid_q, done_q;

    logic              issue;
    logic              first_off, last_off, last_win, last_addr;
    logic              gt;
    logic [DATA_W-1:0] max_d, res_d;

    assign first_off = (off_r_q == '0) && (off_c_q == '0);
    assign last_off  = (off_r_q == OFF_MAX) && (off_c_q == OFF_MAX);
    assign last_win  = (win_x_q == WX_MAX) && (win_y_q == WY_MAX);
    assign last_addr = last_off && last_win;

    // Row-major address of the current (window, offset) position
    assign rd_addr = (ADDR_W'(win_y_q) * POOL_A + ADDR_W'(off_r_q)) * IMGW_A
                   + ADDR_W'(win_x_q) * POOL_A + ADDR_W'(off_c_q);
    assign rd_en   = issue;

    // FSM next state and issue strobe
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = WAIT_SRC;
            end
            WAIT_SRC: begin
                issue = src_ready;
                if (src_ready && last_addr) state_d = FLUSH;
                else if (src_complete)      state_d = RUN;
            end
            RUN: begin
                issue = 1'b1;
                if (last_addr) state_d = FLUSH;
            end
            FLUSH: begin
                if (vld_q && last_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Nested counters: column offset -> row offset -> window column -> window row
    always_comb begin
        off_r_d = off_r_q;
        off_c_d = off_c_q;
        win_x_d = win_x_q;
        win_y_d = win_y_q;
        if (state_q == IDLE) begin
            off_r_d = '0;
            off_c_d = '0;
            win_x_d = '0;
            win_y_d = '0;
        end else if (issue) begin
            if (off_c_q != OFF_MAX) begin
                off_c_d = off_c_q + OW'(1);
            end else begin
                off_c_d = '0;
                if (off_r_q != OFF_MAX) begin
                    off_r_d = off_r_q + OW'(1);
                end else begin
                    off_r_d = '0;
                    if (win_x_q != WX_MAX) begin
                        win_x_d = win_x_q + XW'(1);
                    end else begin
                        win_x_d = '0;
                        if (win_y_q != WY_MAX) win_y_d = win_y_q + YW'(1);
                        else                   win_y_d = '0;
                    end
                end
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            off_r_q <= '0;
            off_c_q <= '0;
            win_x_q <= '0;
            win_y_q <= '0;
        end else begin
            off_r_q <= off_r_d;
            off_c_q <= off_c_d;
            win_x_q <= win_x_d;
            win_y_q <= win_y_d;
        end
    end

    // Running maximum; the first sample of a window always loads
`ifdef RELU_POOL_RELU_EN
    assign gt    = $signed(d_in) > $signed(acc_q);
    assign res_d = max_d[DATA_W-1] ? '0 : max_d;
`else
    assign gt    = d_in > acc_q;
    assign res_d = max_d;
`endif
    assign max_d = (first_q || gt) ? d_in : acc_q;

    // Tag each issued address so only real returns are captured after a stall
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q   <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            vld_q   <= issue;
            first_q <= issue && first_off;
            last_q  <= issue && last_off;
        end
    end

    // Accumulator captures d_in in the cycle after its read strobe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       acc_q <= '0;
        else if (vld_q) acc_q <= max_d;
    end

    // Result register: emits on the last sample of a window, holds otherwise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_out_q     <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            out_valid_q <= vld_q && last_q;
            done_q      <= (state_q == FLUSH) && vld_q && last_q;
            if (vld_q && last_q) d_out_q <= res_d;
        end
    end

    assign d_out     = d_out_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;

endmodule

// File: tb/tb_relu_pool_gen.sv
// tb_relu_pool_gen: directed passes with randomized RAM contents and
// src_ready patterns, checked against a window-by-window reference model.

module tb_relu_pool_gen;

    localparam int DW = 8;
    localparam int W  = 24;
    localparam int H  = 24;
    localparam int P  = 2;
    localparam int AW = 10;
    localparam int NA = W * H;
    localparam int NO = (W / P) * (H / P);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0, src_ready = 1'b0, src_complete = 1'b0;
    logic [DW-1:0] d_in = '0;
    logic          rd_en, out_valid, done;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] d_out;

    // Second, small configuration: 8x4 map, 4x4 windows
    logic          start2 = 1'b0, src_ready2 = 1'b1, src_complete2 = 1'b1;
    logic [DW-1:0] d_in2 = '0;
    logic          rd_en2, out_valid2, done2;
    logic [4:0]    rd_addr2;
    logic [DW-1:0] d_out2;

    logic [DW-1:0] ram [NA];

    int exp_addr [NA];
    int exp_out  [NO];

    int passed = 0, failed = 0, total = 0;

    // Monitor state
    int cyc = 0, done_cnt = 0, done_cyc = 0, last_addr_cyc = 0, last_out_cyc = 0;
    int gap_bad = 0, stall_bad = 0;
    bit chk_stall = 1'b0;
    int addr_q[$];
    int out_q[$];

    relu_pool_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .POOL(P), .ADDR_W(AW)) u_dut (
        .clk(clk), .rst(rst), .start(start), .src_ready(src_ready),
        .src_complete(src_complete), .d_in(d_in), .rd_en(rd_en), .rd_addr(rd_addr),
        .d_out(d_out), .out_valid(out_valid), .done(done)
    );

    relu_pool_gen #(.DATA_W(DW), .IMG_W(8), .IMG_H(4), .POOL(4), .ADDR_W(5)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .src_ready(src_ready2),
        .src_complete(src_complete2), .d_in(d_in2), .rd_en(rd_en2), .rd_addr(rd_addr2),
        .d_out(d_out2), .out_valid(out_valid2), .done(done2)
    );

    initial forever #5 clk = ~clk;

    // Producer RAM models: one-cycle read latency
    always @(posedge clk) if (rd_en)  d_in  <= ram[int'(rd_addr)];
    always @(posedge clk) if (rd_en2) d_in2 <= ram[int'(rd_addr2)];

    // Passive monitor, sampled on the falling edge
    always @(negedge clk) begin
        cyc++;
        if (rd_en) begin
            addr_q.push_back(int'(rd_addr));
            last_addr_cyc = cyc;
        end
        if (chk_stall && rd_en && !src_ready) stall_bad++;
        if (out_valid) begin
            out_q.push_back(int'(d_out));
            if (out_q.size() > 1 && (cyc - last_out_cyc) != P * P) gap_bad++;
            last_out_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sval(input logic [DW-1:0] v);
`ifdef RELU_POOL_RELU_EN
        return int'($signed(v));
`else
        return int'(v);
`endif
    endfunction

    function automatic int relu(input int v);
`ifdef RELU_POOL_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    // Reference: for each window in raster order, list its addresses and take the max
    task automatic build_model();
        int n = 0, m = 0;
        for (int wy = 0; wy < H / P; wy++)
            for (int wx = 0; wx < W / P; wx++) begin
                int best = 0;
                for (int r = 0; r < P; r++)
                    for (int c = 0; c < P; c++) begin
                        int a = (wy * P + r) * W + wx * P + c;
                        exp_addr[n++] = a;
                        if ((r == 0 && c == 0) || sval(ram[a]) > best) best = sval(ram[a]);
                    end
                exp_out[m++] = relu(best);
            end
    endtask

    task automatic clear_mon();
        addr_q.delete();
        out_q.delete();
        done_cnt = 0;
        gap_bad = 0;
        stall_bad = 0;
    endtask

    // mode 0: ready+complete from the start; 1: ready toggles, never complete;
    // 2: random ready, complete after a random delay, stray start mid-pass
    task automatic run_pass(input int mode, input string nm);
        bit fin = 1'b0;
        int cut = $urandom_range(300, 20);
        clear_mon();
        start = 1'b1;
        src_ready = 1'b1;
        src_complete = (mode == 0);
        for (int k = 1; k < 4000 && !fin; k++) begin
            @(posedge clk); #1;
            start = (mode == 2 && k == 60);
            case (mode)
                0: begin src_ready = 1'b1; src_complete = 1'b1; end
                1: begin src_ready = (k % 2 == 0); src_complete = 1'b0; end
                default: begin src_ready = $urandom_range(1, 0) != 0; src_complete = (k >= cut); end
            endcase
            chk_stall = !src_complete;
            if (done_cnt > 0) fin = 1'b1;
        end
        start = 1'b0;
        chk_stall = 1'b0;
        src_ready = 1'b0;
        src_complete = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk({nm, ":done_seen"}, int'(fin), 1);
        chk({nm, ":n_addr"}, addr_q.size(), NA);
        for (int i = 0; i < NA && i < addr_q.size(); i++)
            chk($sformatf("%s:addr[%0d]", nm, i), addr_q[i], exp_addr[i]);
        chk({nm, ":n_out"}, out_q.size(), NO);
        for (int i = 0; i < NO && i < out_q.size(); i++)
            chk($sformatf("%s:out[%0d]", nm, i), out_q[i], exp_out[i]);
        chk({nm, ":done_cnt"}, done_cnt, 1);
        chk({nm, ":done_lat"}, done_cyc - last_addr_cyc, 2);
        chk({nm, ":done_vs_out"}, done_cyc, last_out_cyc);
        chk({nm, ":stall_rd_en"}, stall_bad, 0);
        if (mode == 0) chk({nm, ":gap"}, gap_bad, 0);
    endtask

    function automatic int qat(input int idx);
        return (idx >= 0 && idx < out_q.size()) ? out_q[idx] : -1;
    endfunction

    initial begin
        int n_at_rst;
        int a2_q[$];
        int o2_q[$];
        bit got2;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst:rd_en", int'(rd_en), 0);
        chk("rst:rd_addr", int'(rd_addr), 0);
        chk("rst:d_out", int'(d_out), 0);
        chk("rst:out_valid", int'(out_valid), 0);
        chk("rst:done", int'(done), 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Ramp RAM, uninterrupted pass
        for (int i = 0; i < NA; i++) ram[i] = DW'(i % 256);
        build_model();
        run_pass(0, "ramp");
        chk("ramp:first", qat(0), 25);
        chk("ramp:last", qat(NO - 1), 63);

        // Same data, src_ready toggling, completion never signalled
        run_pass(1, "toggle");
        chk("toggle:first", qat(0), 25);

        // Random data with a directed first window at the sign boundary
        for (int i = 0; i < NA; i++) ram[i] = DW'($urandom);
        ram[0] = 8'h80; ram[1] = 8'h01; ram[W] = 8'h7F; ram[W + 1] = 8'h00;
        build_model();
        run_pass(2, "rand");
`ifdef RELU_POOL_RELU_EN
        chk("rand:win0", qat(0), 127);
`else
        chk("rand:win0", qat(0), 128);
`endif
        run_pass(0, "rand0");

        // Reset during window 10, then a full restart
        for (int i = 0; i < NA; i++) ram[i] = DW'(i % 256);
        build_model();
        clear_mon();
        start = 1'b1; src_ready = 1'b1; src_complete = 1'b1;
        for (int k = 0; k < 200 && addr_q.size() < 42; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        chk("abort:reached", int'(addr_q.size() >= 42), 1);
        #2 rst = 1'b0;
        #1;
        chk("abort:rd_en", int'(rd_en), 0);
        chk("abort:rd_addr", int'(rd_addr), 0);
        chk("abort:d_out", int'(d_out), 0);
        chk("abort:out_valid", int'(out_valid), 0);
        chk("abort:done", int'(done), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        n_at_rst = addr_q.size();
        repeat (10) @(posedge clk);
        #1;
        chk("abort:no_done", done_cnt, 0);
        chk("abort:idle_after", addr_q.size(), n_at_rst);
        run_pass(0, "restart");
        chk("restart:first", qat(0), 25);
        chk("restart:last", qat(NO - 1), 63);

        // 8x4 map with 4x4 windows
        for (int i = 0; i < 32; i++) ram[i] = DW'($urandom);
        got2 = 1'b0;
        @(posedge clk); #1 start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        for (int i = 0; i < 100 && !got2; i++) begin
            @(negedge clk);
            if (rd_en2) a2_q.push_back(int'(rd_addr2));
            if (out_valid2) o2_q.push_back(int'(d_out2));
            if (done2) got2 = 1'b1;
        end
        chk("small:done", int'(got2), 1);
        chk("small:n_addr", a2_q.size(), 32);
        for (int i = 0; i < 16 && i < a2_q.size(); i++)
            chk($sformatf("small:addr[%0d]", i), a2_q[i], (i / 4) * 8 + (i % 4));
        chk("small:n_out", o2_q.size(), 2);
        for (int w = 0; w < 2 && w < o2_q.size(); w++) begin
            int best = sval(ram[w * 4]);
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    if (sval(ram[r * 8 + w * 4 + c]) > best) best = sval(ram[r * 8 + w * 4 + c]);
            chk($sformatf("small:out[%0d]", w), o2_q[w], relu(best));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
